// File: rtl/step_gen.sv
// ============================================================================
// step_gen : velocity-to-step/dir pulse generator for one motion axis.
//
// Integrates a signed velocity word (steps per clk, scaled by 2^31) into a
// fractional phase accumulator and an integer step position. Each integer
// step crossing is queued in a saturating signed pending counter. An output
// FSM drains that counter as step/dir pulses. Each pulse has a guaranteed
// high time, a guaranteed low time, and a guaranteed direction setup time.
//
// Build option:
//   STEP_GEN_OVERRUN_EN  when defined, pending saturation raises the sticky
//                        overrun flag, and clear_overrun_i clears it. When
//                        undefined, pending still saturates but overrun_o
//                        is tied to 0 and clear_overrun_i is ignored.
//
// Ports:
//   clk_i            system clock
//   reset_i          synchronous, active-high reset
//   enable_i         integrate velocity_i this clk
//   velocity_i       signed steps/clk * 2^31 (must come from a register)
//   set_position_i   one-clk strobe: load new_position_i, flush acc/pending
//   new_position_i   value loaded by set_position_i
//   clear_overrun_i  one-clk strobe: clear the sticky overrun flag
//   position_o       logical step position (registered)
//   step_out_o       step pulse (registered)
//   dir_out_o        0 = positive, 1 = negative (registered)
//   busy_o           pending != 0 or FSM not idle (decoded from registers)
//   overrun_o        sticky: the pending counter saturated
// ============================================================================
module step_gen #(
    parameter int unsigned PULSE_WIDTH  = 100,
    parameter int unsigned DIR_SETUP    = 50,
    parameter int unsigned PENDING_BITS = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic signed [31:0] velocity_i,
    input  logic               set_position_i,
    input  logic signed [31:0] new_position_i,
    input  logic               clear_overrun_i,
    output logic signed [31:0] position_o,
    output logic               step_out_o,
    output logic               dir_out_o,
    output logic               busy_o,
    output logic               overrun_o
);

    // ------------------------------------------------------------------
    // Local sizes and constants
    // ------------------------------------------------------------------
    localparam int unsigned TIMER_MAX  = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
    localparam int unsigned TIMER_W    = $clog2(TIMER_MAX + 1);
    localparam int unsigned PEND_EXT_W = PENDING_BITS + 2;

    // One whole step in accumulator units, as a 33-bit signed value.
    localparam logic signed [32:0] STEP_POS = 33'sh0_8000_0000;
    localparam logic signed [32:0] STEP_NEG = 33'sh1_8000_0000;

    // Symmetric saturation limits: +/-(2^(PENDING_BITS-1)-1).
    localparam logic signed [PENDING_BITS-1:0] PEND_MAX =
        {1'b0, {(PENDING_BITS-1){1'b1}}};
    localparam logic signed [PENDING_BITS-1:0] PEND_MIN =
        {1'b1, {(PENDING_BITS-2){1'b0}}, 1'b1};
    localparam logic signed [PEND_EXT_W-1:0] PEND_MAX_EXT = {2'b00, PEND_MAX};
    localparam logic signed [PEND_EXT_W-1:0] PEND_MIN_EXT = {2'b11, PEND_MIN};

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_WIDTH - 1);
    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DIR_SETUP  = 2'd1,
        S_PULSE_HIGH = 2'd2,
        S_PULSE_LOW  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [31:0]             acc_q, acc_d;
    logic signed [31:0]             position_q, position_d;
    logic signed [PENDING_BITS-1:0] pending_q, pending_d;
    state_t                         state_q, state_d;
    logic [TIMER_W-1:0]             timer_q, timer_d;
    logic                           step_q, step_d;
    logic                           dir_q, dir_d;

    // Cross-block combinational signals
    logic signed [31:0]             vel_c;
    logic signed [32:0]             sum;
    logic                           ev_up, ev_dn;
    logic                           cons_pos, cons_neg;
    logic signed [PEND_EXT_W-1:0]   pend_sum;
    logic                           sat;
    logic                           pend_nz;
    logic                           req_dir;

    // ------------------------------------------------------------------
    // Phase integration and position update
    // ------------------------------------------------------------------
    always_comb begin
        // -2^31 is clamped so that the velocity range is symmetric.
        vel_c      = (velocity_i == 32'sh8000_0000) ? 32'sh8000_0001 : velocity_i;
        sum        = {acc_q[31], acc_q} + {vel_c[31], vel_c};
        acc_d      = acc_q;
        position_d = position_q;
        ev_up      = 1'b0;
        ev_dn      = 1'b0;
        if (set_position_i) begin
            position_d = new_position_i;
            acc_d      = '0;
        end else if (enable_i) begin
            if (sum >= STEP_POS) begin
                acc_d      = 32'(sum - STEP_POS);
                position_d = position_q + 32'sd1;
                ev_up      = 1'b1;
            end else if (sum <= STEP_NEG) begin
                acc_d      = 32'(sum + STEP_POS);
                position_d = position_q - 32'sd1;
                ev_dn      = 1'b1;
            end else begin
                acc_d      = 32'(sum);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        step_d   = step_q;
        dir_d    = dir_q;
        cons_pos = 1'b0;
        cons_neg = 1'b0;
        pend_nz  = (pending_q != '0);
        req_dir  = pending_q[PENDING_BITS-1];

        unique case (state_q)
            S_IDLE: begin
                step_d = 1'b0;
                // A position load flushes the queue this clk, so start nothing.
                if (pend_nz && !set_position_i) begin
                    if (req_dir == dir_q) begin
                        state_d  = S_PULSE_HIGH;
                        timer_d  = PULSE_LOAD;
                        step_d   = 1'b1;
                        cons_pos = ~req_dir;
                        cons_neg = req_dir;
                    end else begin
                        state_d = S_DIR_SETUP;
                        timer_d = SETUP_LOAD;
                        dir_d   = ~dir_q;
                    end
                end
            end
            S_DIR_SETUP: begin
                if (timer_q == '0) begin
                    // Pending may have drained or flipped sign during setup.
                    if (pend_nz && (req_dir == dir_q) && !set_position_i) begin
                        state_d  = S_PULSE_HIGH;
                        timer_d  = PULSE_LOAD;
                        step_d   = 1'b1;
                        cons_pos = ~req_dir;
                        cons_neg = req_dir;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_PULSE_HIGH: begin
                if (timer_q == '0) begin
                    state_d = S_PULSE_LOW;
                    timer_d = PULSE_LOAD;
                    step_d  = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_PULSE_LOW: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending counter: add the step event, subtract the consume, saturate
    // ------------------------------------------------------------------
    always_comb begin
        pend_sum  = {{2{pending_q[PENDING_BITS-1]}}, pending_q};
        pending_d = pending_q;
        sat       = 1'b0;
        if (ev_up)    pend_sum = pend_sum + PEND_EXT_W'(1);
        if (ev_dn)    pend_sum = pend_sum - PEND_EXT_W'(1);
        if (cons_pos) pend_sum = pend_sum - PEND_EXT_W'(1);
        if (cons_neg) pend_sum = pend_sum + PEND_EXT_W'(1);
        if (set_position_i) begin
            pending_d = '0;
        end else if (pend_sum > PEND_MAX_EXT) begin
            pending_d = PEND_MAX;
            sat       = 1'b1;
        end else if (pend_sum < PEND_MIN_EXT) begin
            pending_d = PEND_MIN;
            sat       = 1'b1;
        end else begin
            pending_d = pend_sum[PENDING_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q      <= '0;
            position_q <= '0;
            pending_q  <= '0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            position_q <= position_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overrun flag (set wins over a same-clk clear)
    // ------------------------------------------------------------------
`ifdef STEP_GEN_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (clear_overrun_i) overrun_d = 1'b0;
        if (sat)             overrun_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    logic unused_ovr;
    assign unused_ovr = clear_overrun_i ^ sat;
    assign overrun_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign position_o = position_q;
    assign step_out_o = step_q;
    assign dir_out_o  = dir_q;
    // busy is decoded from registered state only.
    assign busy_o     = (pending_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_step_gen.sv
// Scoreboarded bench for step_gen with PULSE_WIDTH=4 and DIR_SETUP=3.
// dut1 has PENDING_BITS=8 and dut2 has PENDING_BITS=4 (the saturation case).
module tb_step_gen;

    localparam int unsigned PW = 4;
    localparam int unsigned DS = 3;

`ifdef STEP_GEN_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    typedef struct packed {
        logic dir;
        logic setup;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, en2, set_pos, clr, clr2;
    logic signed [31:0] velocity, new_pos;
    logic signed [31:0] pos1, pos2;
    logic step1, dir1, busy1, ovr1;
    logic step2, dir2, busy2, ovr2;

    step_gen #(.PULSE_WIDTH(PW), .DIR_SETUP(DS), .PENDING_BITS(8)) dut1 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .velocity_i(velocity),
        .set_position_i(set_pos), .new_position_i(new_pos), .clear_overrun_i(clr),
        .position_o(pos1), .step_out_o(step1), .dir_out_o(dir1),
        .busy_o(busy1), .overrun_o(ovr1)
    );

    step_gen #(.PULSE_WIDTH(PW), .DIR_SETUP(DS), .PENDING_BITS(4)) dut2 (
        .clk_i(clk), .reset_i(reset), .enable_i(en2), .velocity_i(velocity),
        .set_position_i(set_pos), .new_position_i(new_pos), .clear_overrun_i(clr2),
        .position_o(pos2), .step_out_o(step2), .dir_out_o(dir2),
        .busy_o(busy2), .overrun_o(ovr2)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   p2_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for dut1: pops one expected pulse per step rise and checks
    // the pulse shape and the direction timing.
    initial begin
        logic prev_step, prev_dir, prev2, rise, fall, seen_fall;
        int hi_cnt, lo_cnt, dir_age;
        exp_t e;
        prev_step = 0; prev_dir = 0; prev2 = 0; seen_fall = 0;
        hi_cnt = 0; lo_cnt = 0; dir_age = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_step = 0; prev_dir = 0; prev2 = 0; seen_fall = 0;
                hi_cnt = 0; lo_cnt = 0; dir_age = 0;
            end else begin
                rise = step1 && !prev_step;
                fall = !step1 && prev_step;
                if (dir1 !== prev_dir) begin
                    dir_age = 0;
                    check("dir_change_only_when_idle",
                          32'((!step1 && (!seen_fall || lo_cnt >= int'(PW + 1))) ? 1 : 0), 32'd1);
                end else begin
                    dir_age++;
                end
                if (rise) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got step rise with dir=%0d, required none", dir1);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_dir", 32'(dir1), 32'(e.dir));
                        if (e.setup) check("dir_setup_clks", 32'(dir_age), 32'(DS));
                    end
                    if (seen_fall)
                        check("min_low_time", 32'((lo_cnt >= int'(PW + 1)) ? 1 : 0), 32'd1);
                    hi_cnt = 1;
                end else if (step1) begin
                    hi_cnt++;
                end
                if (fall) begin
                    check("pulse_high_clks", 32'(hi_cnt), 32'(PW));
                    seen_fall = 1;
                    lo_cnt    = 1;
                end else if (!step1) begin
                    lo_cnt++;
                end
                if (step2 && !prev2) p2_rises++;
                prev_step = step1;
                prev_dir  = dir1;
                prev2     = step2;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; en2 = 0; set_pos = 0; clr = 0; clr2 = 0;
        velocity = '0; new_pos = '0;
        tick();
        tick();
        reset = 0;
        sb.delete();
    endtask

    task automatic run_enable(input int n);
        enable = 1;
        repeat (n) tick();
        enable = 0;
    endtask

    task automatic push_n(input int n, input logic dir, input logic first_setup);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.dir   = dir;
            e.setup = (i == 0) ? first_setup : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy1 || busy2) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_busy1_idle"}, 32'(busy1), 32'd0);
        check({name, "_busy2_idle"}, 32'(busy2), 32'd0);
    endtask

    task automatic wait_step(input string name);
        int n = 0;
        while (!step1 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(step1), 32'd1);
    endtask

    initial begin
        int base;
        do_reset();
        check("rst_position", pos1, 32'd0);
        check("rst_step", 32'(step1), 32'd0);
        check("rst_dir", 32'(dir1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_overrun", 32'(ovr1), 32'd0);

        // Half-rate forward: 8 clks at 0.5 step/clk
        velocity = 32'h4000_0000;
        push_n(4, 1'b0, 1'b0);
        run_enable(8);
        check("fwd_position", pos1, 32'd4);
        wait_idle("fwd");
        check("fwd_all_pulses", 32'(sb.size()), 32'd0);
        check("fwd_dir", 32'(dir1), 32'd0);

        // Reverse at 0.25 step/clk with direction setup
        do_reset();
        velocity = 32'hE000_0000;
        push_n(4, 1'b1, 1'b1);
        run_enable(16);
        check("rev_position", pos1, 32'hFFFF_FFFC);
        wait_idle("rev");
        check("rev_all_pulses", 32'(sb.size()), 32'd0);
        check("rev_dir", 32'(dir1), 32'd1);

        // -2^31 is clamped: no step on the first clk, one step on the second
        do_reset();
        velocity = 32'h8000_0000;
        push_n(1, 1'b1, 1'b1);
        run_enable(1);
        check("clamp_pos_1clk", pos1, 32'd0);
        run_enable(1);
        check("clamp_pos_2clk", pos1, 32'hFFFF_FFFF);
        wait_idle("clamp");
        check("clamp_all_pulses", 32'(sb.size()), 32'd0);

        // Max rate: 40 clks -> 39 steps, all drained
        do_reset();
        velocity = 32'h7FFF_FFFF;
        push_n(39, 1'b0, 1'b0);
        run_enable(40);
        check("max_position", pos1, 32'd39);
        wait_idle("max");
        check("max_all_pulses", 32'(sb.size()), 32'd0);
        check("max_no_overrun", 32'(ovr1), 32'd0);

        // Overrun on the 4-bit pending counter: 5 pulses during the run, then
        // 7 held at saturation, for 12 in total.
        do_reset();
        base = p2_rises;
        velocity = 32'h7FFF_FFFF;
        en2 = 1;
        repeat (40) tick();
        en2 = 0;
        check("ovr_position", pos2, 32'd39);
        check("ovr_flag", 32'(ovr2), 32'(OVR_EN));
        wait_idle("ovr");
        check("ovr_pulse_count", 32'(p2_rises - base), 32'd12);
        check("ovr_dir", 32'(dir2), 32'd0);
        check("ovr_sticky", 32'(ovr2), 32'(OVR_EN));
        clr2 = 1;
        tick();
        clr2 = 0;
        check("ovr_cleared", 32'(ovr2), 32'd0);

        // set_position while step_out is high
        do_reset();
        velocity = 32'h4000_0000;
        push_n(1, 1'b0, 1'b0);
        enable = 1;
        wait_step("sp_step_seen");
        enable  = 0;
        set_pos = 1;
        new_pos = 32'd1000;
        tick();
        set_pos = 0;
        check("sp_position", pos1, 32'd1000);
        wait_idle("sp");
        check("sp_no_more_pulses", 32'(sb.size()), 32'd0);
        check("sp_position_hold", pos1, 32'd1000);

        // Reset during PULSE_HIGH after a reverse-direction setup
        do_reset();
        velocity = 32'h8000_0001;
        push_n(1, 1'b1, 1'b1);
        enable = 1;
        wait_step("rm_step_seen");
        check("rm_dir_before", 32'(dir1), 32'd1);
        enable = 0;
        reset  = 1;
        tick();
        check("rm_step", 32'(step1), 32'd0);
        check("rm_dir", 32'(dir1), 32'd0);
        check("rm_position", pos1, 32'd0);
        check("rm_busy", 32'(busy1), 32'd0);
        reset = 0;
        sb.delete();
        tick();
        check("rm_stays_idle", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_gen.md
Name: step_gen

Overview:
- Downstream of the motion planner (dda) on each axis. Each clk it integrates the signed velocity word into a fractional phase accumulator and an integer step position.
- The position output feeds back to the planner's position input.
- Integer step crossings are queued in a bounded pending counter. An output FSM drains the counter as step/dir pulses with guaranteed pulse width and direction setup time for an external driver.

Parameters:
- PULSE_WIDTH, 100: clk cycles step_out is held high, and also the minimum low time (1 us at 100 MHz).
- DIR_SETUP, 50: clk cycles dir_out must be stable before a step_out rising edge.
- PENDING_BITS, 8: width of the signed pending-step counter. Saturation limit is ±(2^(PENDING_BITS-1)-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 1, integrate velocity this clk.
- velocity  in  32 signed  steps per clk, scaled by 2^31. Must be driven from a registered source, such as the dda velocity output.
- set_position  in  1  one-clk strobe that loads new_position.
- new_position  in  32 signed  value loaded by set_position.
- clear_overrun  in  1  one-clk strobe that clears overrun.
- position  out  32 signed  logical step position (registered).
- step_out  out  1  step pulse (registered).
- dir_out  out  1  0 = positive direction, 1 = negative (registered).
- busy  out  1  1 when pending != 0 or the FSM is not in IDLE.
- overrun  out  1  sticky flag: the pending counter saturated.

Behaviour:
- Reset: acc, position and pending = 0. step_out, dir_out, busy and overrun = 0. FSM = IDLE. Timers = 0.
- Integration, each clk with enable=1 and set_position=0:
  - v = velocity, except velocity = -2^31 is clamped to -(2^31-1).
  - sum = acc (33-bit signed) + sign-extended v.
  - If sum >= 2^31: acc <= sum - 2^31, position +1, step event +1.
  - Else if sum <= -2^31: acc <= sum + 2^31, position -1, step event -1.
  - Else: acc <= sum, no step event.
  - At most one step event occurs per clk. position wraps modulo 2^32.
- enable=0: acc, position and the integration input are frozen. The output FSM keeps draining pending.
- set_position: takes priority over integration in the same clk.
  - Next clk: position = new_position, acc = 0, pending = 0.
  - An in-flight pulse or setup phase completes normally; nothing further is emitted.
- pending: next = pending + step_event - consume, where consume is ±1 on entry to PULSE_HIGH.
  - Integration and consume in the same clk net out.
  - If next would exceed ±limit, pending holds at the limit and overrun is set.
  - The position update is never blocked by saturation.
- overrun: sticky. Cleared by clear_overrun. If clear and set occur in the same clk, set wins.
- FSM states: IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW.
  - IDLE with pending != 0 and required dir (pending < 0) equal to dir_out: go to PULSE_HIGH next clk. step_out = 1 and pending is consumed on that edge.
  - IDLE with pending != 0 and required dir different from dir_out: dir_out toggles on that edge, go to DIR_SETUP, timer = DIR_SETUP.
  - DIR_SETUP: after DIR_SETUP clks, go to PULSE_HIGH. Direction is re-evaluated here: if pending is now 0 or has the opposite sign, return to IDLE.
  - PULSE_HIGH: step_out = 1 for exactly PULSE_WIDTH clks, then PULSE_LOW.
  - PULSE_LOW: step_out = 0 for PULSE_WIDTH clks, then IDLE.
- Minimum step period is 2*PULSE_WIDTH+1 clks.
- dir_out changes only on IDLE to DIR_SETUP transitions. It never changes while step_out = 1 or during PULSE_LOW.
- busy is combinational from registered state.

Optional Feature:
- Macro: STEP_GEN_OVERRUN_EN.
- Defined: saturation detection, the sticky overrun flag and clear_overrun behave as above.
- Undefined: pending still saturates silently, overrun is tied to 0, and clear_overrun is ignored.

Test Plan:
All scenarios use PULSE_WIDTH=4, DIR_SETUP=3, PENDING_BITS=8 unless stated.
- Half-rate forward: reset; velocity=0x40000000, enable=1 for 8 clks, then enable=0 -> position=4. Exactly 4 step_out pulses, each 4 clks high. dir_out stays 0. busy falls after the last PULSE_LOW.
- Reverse with setup: velocity=-0x20000000 for 16 clks -> position=-4. dir_out rises once. The first step_out rise is exactly 3 clks after the dir_out change. 4 pulses total.
- Max rate timing: velocity=0x7FFFFFFF for 40 clks -> position=39. step_out is high 4 clks and low >= 5 clks every period. Pulse count equals 39 once busy drops.
- Overrun (PENDING_BITS=4): velocity=0x7FFFFFFF for 40 clks -> pending holds at 7 and overrun=1. position is still 39. A clear_overrun pulse -> overrun=0 next clk. Built without STEP_GEN_OVERRUN_EN -> overrun stays 0.
- set_position mid-pulse: while step_out=1, strobe set_position with new_position=1000 -> position=1000 next clk, pending=0. The current pulse still lasts 4 clks high. No further pulses.
- Reset mid-pulse: assert reset during PULSE_HIGH -> next clk step_out=0, dir_out=0, position=0, busy=0, FSM in IDLE.
